reverb_param_loader: RTL and testbench

- Writer side of the reverberator core's parameter interface.
- Receives framed byte writes from the MCU link into a shadow bank of 6 tau words and 7 gain words.
- Range-clamps each word as it is written.
- Commits the shadow bank atomically to registered `tau`/`gain` outputs on the next `sample_clk` rising edge, so the core never sees a half-updated set within a sample.

---
 rtl/reverb_param_loader_pkg.sv | 32 +++
 rtl/reverb_param_loader_if.sv | 9 +
 rtl/reverb_param_loader_sync_edge_detect.sv | 21 ++
 rtl/reverb_param_loader.sv | 215 +++++++++++++++++++++
 tb/tb_reverb_param_loader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/reverb_param_loader_pkg.sv
// Shared constants, FSM state encoding and clamp limits for the reverb parameter loader.
// The CHECK state exists only when REVERB_PARAM_CHECKSUM_EN is defined.
`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 4096
`endif

package reverb_param_loader_pkg;
  localparam int FP                = `FIXED_POINT;
  localparam int W                 = 24 + FP;
  localparam int MAX_DELAY_DEFAULT = `MAX_FILTER_FIFO_LENGTH;
  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int NTAU   = 6;
  localparam int NGAIN  = 7;
  localparam int NPARAM = NTAU + NGAIN;

  localparam logic [W-1:0] TAU_LIMIT  = W'(MAX_DELAY_DEFAULT << FP);
  localparam logic [W-1:0] GAIN_LIMIT = W'((1 << FP) - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_COUNT,
    ST_DATA,
`ifdef REVERB_PARAM_CHECKSUM_EN
    ST_CHECK,
`endif
    ST_PEND
  } state_t;
endpackage

// File: rtl/reverb_param_loader_if.sv
// Byte-stream link from the MCU into the parameter loader (valid/ready handshake).
interface reverb_param_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/reverb_param_loader_sync_edge_detect.sv
// 2-FF synchroniser for a slow clock-like signal plus a rising-edge pulse in the clk domain.
module sync_edge_detect (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], din};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= '0;
    else       sync_q <= sync_d;
  end

  // sync_q[2] is the edge register: pulse is high for one cycle after the synchronised rise.
  assign rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/reverb_param_loader.sv
// Framed byte loader for reverb tau/gain words with clamping and atomic per-sample commit.
// Optional checksum byte after the data is enabled by REVERB_PARAM_CHECKSUM_EN.
module reverb_param_loader
  import reverb_param_loader_pkg::*;
#(
  parameter int WIDTH    = 24,
  parameter int MAXDELAY = MAX_DELAY_DEFAULT,
  parameter int TAU_RST  = 1,
  localparam int WW      = WIDTH + FP
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       sample_clk,
  reverb_param_loader_if.slave       in_if,
  output logic [0:NTAU-1][WW-1:0]    tau,
  output logic [0:NGAIN-1][WW-1:0]   gain,
  output logic                       commit,
  output logic                       frame_err
);
  typedef logic [0:NPARAM-1][WW-1:0] bank_t;

  localparam logic [WW-1:0] TAU_RST_W = WW'(TAU_RST << FP);
  localparam logic [WW-1:0] TAU_LIM   = WW'(MAXDELAY << FP);
  localparam logic [WW-1:0] GAIN_LIM  = WW'(GAIN_LIMIT);

  function automatic bank_t reset_bank();
    bank_t b;
    for (int i = 0; i < NPARAM; i++) b[i] = (i < NTAU) ? TAU_RST_W : '0;
    return b;
  endfunction

  localparam bank_t RST_BANK = reset_bank();

  function automatic logic [WW-1:0] clamp(input logic [WW-1:0] v, input logic [WW-1:0] lim);
    if (v[WW-1]) return '0;
    if (v > lim) return lim;
    return v;
  endfunction

  state_t          state_q, state_d;
  logic [7:0]      addr_q, addr_d;
  logic [3:0]      count_q, count_d;
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [3:0]      word_cnt_q, word_cnt_d;
  logic [WW-9:0]   word_q, word_d;
  logic [7:0]      cks_q, cks_d;
  logic            wr_pend_q, wr_pend_d;
  logic [3:0]      wr_idx_q, wr_idx_d;
  logic [WW-1:0]   wr_data_q, wr_data_d;
  logic            restore_q, restore_d;
  logic            pend_new_q, pend_new_d;
  logic            commit_q, commit_d;
  logic            frame_err_q, frame_err_d;
  bank_t           shadow_q, shadow_d;
  bank_t           active_q, active_d;
  logic            sample_rise;
  logic            xfer;

  sync_edge_detect u_sync (
    .clk  (clk),
    .rstn (rstn),
    .din  (sample_clk),
    .rise (sample_rise)
  );

  assign in_if.in_ready = (state_q != ST_PEND);
  assign xfer           = in_if.in_valid && in_if.in_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    byte_cnt_d  = byte_cnt_q;
    word_cnt_d  = word_cnt_q;
    word_d      = word_q;
    cks_d       = cks_q;
    wr_pend_d   = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    restore_d   = 1'b0;
    commit_d    = 1'b0;
    frame_err_d = 1'b0;
    shadow_d    = shadow_q;
    active_d    = active_q;

    if (wr_pend_q)
      shadow_d[wr_idx_q] = clamp(wr_data_q, (wr_idx_q < 4'(NTAU)) ? TAU_LIM : GAIN_LIM);
    // Restore follows the rejection by a cycle so it always lands after any in-flight word write.
    if (restore_q)
      shadow_d = active_q;

    case (state_q)
      ST_IDLE: begin
        if (xfer && in_if.in_data == FRAME_HDR) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        if (xfer) begin
          addr_d  = in_if.in_data;
          cks_d   = in_if.in_data;
          state_d = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (xfer) begin
          count_d    = in_if.in_data[3:0];
          cks_d      = cks_q ^ in_if.in_data;
          byte_cnt_d = '0;
          word_cnt_d = '0;
          if (in_if.in_data == 8'd0 ||
              ({1'b0, addr_q} + {1'b0, in_if.in_data}) > 9'(NPARAM)) begin
            frame_err_d = 1'b1;
            restore_d   = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (xfer) begin
          cks_d      = cks_q ^ in_if.in_data;
          word_d     = {word_q[WW-17:0], in_if.in_data};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_pend_d  = 1'b1;
            wr_idx_d   = addr_q[3:0] + word_cnt_q;
            wr_data_d  = {word_q, in_if.in_data};
            word_cnt_d = word_cnt_q + 4'd1;
            if (word_cnt_q == count_q - 4'd1) begin
`ifdef REVERB_PARAM_CHECKSUM_EN
              state_d = ST_CHECK;
`else
              state_d = ST_PEND;
`endif
            end
          end
        end
      end
`ifdef REVERB_PARAM_CHECKSUM_EN
      ST_CHECK: begin
        if (xfer) begin
          if (in_if.in_data == cks_q) begin
            state_d = ST_PEND;
          end else begin
            frame_err_d = 1'b1;
            restore_d   = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end
`endif
      ST_PEND: begin
        // An edge seen in the entry cycle is skipped; the last word is still landing in shadow.
        if (sample_rise && !pend_new_q) begin
          active_d = shadow_q;
          commit_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pend_new_d = (state_d == ST_PEND) && (state_q != ST_PEND);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      byte_cnt_q  <= '0;
      word_cnt_q  <= '0;
      word_q      <= '0;
      cks_q       <= '0;
      wr_pend_q   <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      restore_q   <= 1'b0;
      pend_new_q  <= 1'b0;
      commit_q    <= 1'b0;
      frame_err_q <= 1'b0;
      shadow_q    <= RST_BANK;
      active_q    <= RST_BANK;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      byte_cnt_q  <= byte_cnt_d;
      word_cnt_q  <= word_cnt_d;
      word_q      <= word_d;
      cks_q       <= cks_d;
      wr_pend_q   <= wr_pend_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      restore_q   <= restore_d;
      pend_new_q  <= pend_new_d;
      commit_q    <= commit_d;
      frame_err_q <= frame_err_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NTAU; gi++) begin : g_tau
      assign tau[gi] = active_q[gi];
    end
    for (genvar gi = 0; gi < NGAIN; gi++) begin : g_gain
      assign gain[gi] = active_q[NTAU + gi];
    end
  endgenerate

  assign commit    = commit_q;
  assign frame_err = frame_err_q;
endmodule

// File: tb/tb_reverb_param_loader.sv
// Directed self-checking bench for reverb_param_loader (FIXED_POINT=8, MAX delay 4096).
// Frames gain a checksum byte automatically when REVERB_PARAM_CHECKSUM_EN is defined.
module tb_reverb_param_loader;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic sample_clk = 1'b0;
  logic [0:5][31:0] tau;
  logic [0:6][31:0] gain;
  logic commit;
  logic frame_err;
  logic [31:0] fw [0:12];
  int n_checks = 0;
  int n_fail = 0;

  reverb_param_loader_if bus ();

  reverb_param_loader dut (
    .clk        (clk),
    .rstn       (rstn),
    .sample_clk (sample_clk),
    .in_if      (bus),
    .tau        (tau),
    .gain       (gain),
    .commit     (commit),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-14s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && t < 100) begin
      tick();
      t++;
    end
    check("send_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] addr, input logic [7:0] cnt, input bit bad_cks);
    logic [7:0] cks;
    logic [31:0] w;
    send_byte(8'hA5);
    send_byte(addr);
    send_byte(cnt);
    cks = addr ^ cnt;
    for (int i = 0; i < cnt; i++) begin
      w = fw[i];
      for (int j = 3; j >= 0; j--) begin
        send_byte(w[j*8 +: 8]);
        cks = cks ^ w[j*8 +: 8];
      end
    end
`ifdef REVERB_PARAM_CHECKSUM_EN
    send_byte(bad_cks ? (cks ^ 8'h01) : cks);
`else
    if (bad_cks) $display("checksum option disabled, no checksum byte sent");
`endif
  endtask

  // Raise sample_clk, expect commit exactly on the third clk edge after it (or never).
  task automatic do_commit(input logic exp);
    sample_clk = 1'b1;
    tick();
    tick();
    check("pre_commit", {31'd0, commit}, 32'd0);
    check("pend_ready", {31'd0, bus.in_ready}, {31'd0, ~exp});
    tick();
    check("commit_edge", {31'd0, commit}, {31'd0, exp});
    tick();
    check("commit_pulse", {31'd0, commit}, 32'd0);
    sample_clk = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Reset state
    for (int i = 0; i < 6; i++) check("rst_tau", tau[i], 32'h0000_0100);
    for (int i = 0; i < 7; i++) check("rst_gain", gain[i], 32'h0);
    check("rst_commit", {31'd0, commit}, 32'd0);
    check("rst_ferr", {31'd0, frame_err}, 32'd0);
    check("rst_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single gain word; in_valid held high through PEND
    fw[0] = 32'h0000_00B3;
    send_frame(8'h06, 8'h01, 1'b0);
    check("pend_ready0", {31'd0, bus.in_ready}, 32'd0);
    check("no_early", gain[0], 32'h0);
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b1;
    repeat (4) tick();
    check("hold_ready0", {31'd0, bus.in_ready}, 32'd0);
    check("hold_noupd", gain[0], 32'h0);
    do_commit(1'b1);
    bus.in_valid = 1'b0;
    check("g0_b3", gain[0], 32'h0000_00B3);
    check("t0_keep", tau[0], 32'h0000_0100);
    check("g1_keep", gain[1], 32'h0);
    check("idle_ready", {31'd0, bus.in_ready}, 32'd1);

    // Clamping: tau2 neg, tau3 plain, tau4 over, tau5 at limit, gain0 at limit, gain1 over
    fw[0] = 32'hFFFF_FF00;
    fw[1] = 32'h0000_0200;
    fw[2] = 32'h7FFF_FFFF;
    fw[3] = 32'h0010_0000;
    fw[4] = 32'h0000_00FF;
    fw[5] = 32'h0000_0200;
    send_frame(8'h02, 8'h06, 1'b0);
    do_commit(1'b1);
    check("t2_neg", tau[2], 32'h0);
    check("t3_plain", tau[3], 32'h0000_0200);
    check("t4_over", tau[4], 32'h0010_0000);
    check("t5_limit", tau[5], 32'h0010_0000);
    check("g0_limit", gain[0], 32'h0000_00FF);
    check("g1_over", gain[1], 32'h0000_00FF);
    check("t1_keep", tau[1], 32'h0000_0100);
    check("g2_keep", gain[2], 32'h0);

    // Range error: ADDR 12 + COUNT 2 > 13
    send_byte(8'hA5);
    send_byte(8'h0C);
    send_byte(8'h02);
    check("ferr_range", {31'd0, frame_err}, 32'd1);
    tick();
    check("ferr_pulse", {31'd0, frame_err}, 32'd0);
    // COUNT == 0
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h00);
    check("ferr_cnt0", {31'd0, frame_err}, 32'd1);
    do_commit(1'b0);
    check("rej_t2", tau[2], 32'h0);
    check("rej_g1", gain[1], 32'h0000_00FF);

    // ADDR 12 + COUNT 1 == 13 is the last legal word
    fw[0] = 32'h0000_0080;
    send_frame(8'h0C, 8'h01, 1'b0);
    check("edge_noerr", {31'd0, frame_err}, 32'd0);
    do_commit(1'b1);
    check("g6_80", gain[6], 32'h0000_0080);
    check("g6_t2keep", tau[2], 32'h0);
    check("g6_g1keep", gain[1], 32'h0000_00FF);

    // Reset mid-DATA
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    rstn = 1'b0;
    #1;
    check("mrst_t2", tau[2], 32'h0000_0100);
    check("mrst_g6", gain[6], 32'h0);
    check("mrst_g1", gain[1], 32'h0);
    check("mrst_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    rstn = 1'b1;
    tick();
    fw[0] = 32'h0000_0100;
    send_frame(8'h07, 8'h01, 1'b0);
    do_commit(1'b1);
    check("post_g1", gain[1], 32'h0000_00FF);
    check("post_t0", tau[0], 32'h0000_0100);
    check("post_g6", gain[6], 32'h0);

`ifdef REVERB_PARAM_CHECKSUM_EN
    // Bad checksum undoes the shadow write of tau1
    fw[0] = 32'h0000_0300;
    send_frame(8'h01, 8'h01, 1'b1);
    check("cks_ferr", {31'd0, frame_err}, 32'd1);
    check("cks_ready", {31'd0, bus.in_ready}, 32'd1);
    tick();
    fw[0] = 32'h0000_0040;
    send_frame(8'h0C, 8'h01, 1'b0);
    check("cks_ok", {31'd0, frame_err}, 32'd0);
    do_commit(1'b1);
    check("cks_t1", tau[1], 32'h0000_0100);
    check("cks_g6", gain[6], 32'h0000_0040);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
